// File: rtl/tile_seq_pkg.sv
`default_nettype none
// tile_seq_pkg: shared FSM state encoding and default widths for the tile sequencer.
package tile_seq_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_CNT_WIDTH  = 8;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD       = 4'd1,
    ST_WAIT_LOAD  = 4'd2,
    ST_COMP       = 4'd3,
    ST_WAIT_COMP  = 4'd4,
    ST_STORE      = 4'd5,
    ST_WAIT_STORE = 4'd6,
    ST_NEXT       = 4'd7,
    ST_DONE       = 4'd8
  } tile_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/tile_addr_gen.sv
`default_nettype none
// tile_addr_gen: running per-tile DRAM address accumulators (no multipliers).
// init loads bases/strides, step_e advances along e, step_m starts the next m row.
module tile_addr_gen
  import tile_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  step_e,
  input  logic                  step_m,
  input  logic [ADDR_WIDTH-1:0] ifmap_base,
  input  logic [ADDR_WIDTH-1:0] filter_base,
  input  logic [ADDR_WIDTH-1:0] bias_base,
  input  logic [ADDR_WIDTH-1:0] opsum_base,
  input  logic [ADDR_WIDTH-1:0] ifmap_e_stride,
  input  logic [ADDR_WIDTH-1:0] filter_m_stride,
  input  logic [ADDR_WIDTH-1:0] bias_m_stride,
  input  logic [ADDR_WIDTH-1:0] opsum_m_stride,
  input  logic [ADDR_WIDTH-1:0] opsum_e_stride,
  output logic [ADDR_WIDTH-1:0] tile_ifmap_addr,
  output logic [ADDR_WIDTH-1:0] tile_filter_addr,
  output logic [ADDR_WIDTH-1:0] tile_bias_addr,
  output logic [ADDR_WIDTH-1:0] tile_opsum_addr
);

  logic [ADDR_WIDTH-1:0] ifmap_base_q;
  logic [ADDR_WIDTH-1:0] ifmap_e_stride_q;
  logic [ADDR_WIDTH-1:0] filter_m_stride_q;
  logic [ADDR_WIDTH-1:0] bias_m_stride_q;
  logic [ADDR_WIDTH-1:0] opsum_m_stride_q;
  logic [ADDR_WIDTH-1:0] opsum_e_stride_q;
  // Opsum address of tile (m, 0); the e walk restarts from here on every m step.
  logic [ADDR_WIDTH-1:0] opsum_row_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ifmap_base_q      <= '0;
      ifmap_e_stride_q  <= '0;
      filter_m_stride_q <= '0;
      bias_m_stride_q   <= '0;
      opsum_m_stride_q  <= '0;
      opsum_e_stride_q  <= '0;
      opsum_row_q       <= '0;
      tile_ifmap_addr   <= '0;
      tile_filter_addr  <= '0;
      tile_bias_addr    <= '0;
      tile_opsum_addr   <= '0;
    end else if (init) begin
      ifmap_base_q      <= ifmap_base;
      ifmap_e_stride_q  <= ifmap_e_stride;
      filter_m_stride_q <= filter_m_stride;
      bias_m_stride_q   <= bias_m_stride;
      opsum_m_stride_q  <= opsum_m_stride;
      opsum_e_stride_q  <= opsum_e_stride;
      opsum_row_q       <= opsum_base;
      tile_ifmap_addr   <= ifmap_base;
      tile_filter_addr  <= filter_base;
      tile_bias_addr    <= bias_base;
      tile_opsum_addr   <= opsum_base;
    end else if (step_m) begin
      tile_ifmap_addr  <= ifmap_base_q;
      tile_filter_addr <= tile_filter_addr + filter_m_stride_q;
      tile_bias_addr   <= tile_bias_addr + bias_m_stride_q;
      opsum_row_q      <= opsum_row_q + opsum_m_stride_q;
      tile_opsum_addr  <= opsum_row_q + opsum_m_stride_q;
    end else if (step_e) begin
      tile_ifmap_addr <= tile_ifmap_addr + ifmap_e_stride_q;
      tile_opsum_addr <= tile_opsum_addr + opsum_e_stride_q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tile_sequencer.sv
`default_nettype none
// tile_sequencer: walks m (outer) x e (inner) tiles, pulsing load/comp/store per tile.
// Optional TILE_SEQ_PERF_EN adds perf_busy_cycles / perf_wait_cycles counters.
module tile_sequencer
  import tile_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_m_tiles,
  input  logic [CNT_WIDTH-1:0]  num_e_tiles,
  input  logic [ADDR_WIDTH-1:0] dram_ifmap_base_addr,
  input  logic [ADDR_WIDTH-1:0] dram_filter_base_addr,
  input  logic [ADDR_WIDTH-1:0] dram_bias_base_addr,
  input  logic [ADDR_WIDTH-1:0] dram_opsum_base_addr,
  input  logic [ADDR_WIDTH-1:0] ifmap_e_stride,
  input  logic [ADDR_WIDTH-1:0] filter_m_stride,
  input  logic [ADDR_WIDTH-1:0] bias_m_stride,
  input  logic [ADDR_WIDTH-1:0] opsum_m_stride,
  input  logic [ADDR_WIDTH-1:0] opsum_e_stride,
  input  logic                  load_done,
  input  logic                  comp_done,
  input  logic                  store_done,
  output logic [ADDR_WIDTH-1:0] tile_ifmap_addr,
  output logic [ADDR_WIDTH-1:0] tile_filter_addr,
  output logic [ADDR_WIDTH-1:0] tile_bias_addr,
  output logic [ADDR_WIDTH-1:0] tile_opsum_addr,
  output logic [CNT_WIDTH-1:0]  tile_m_idx,
  output logic [CNT_WIDTH-1:0]  tile_e_idx,
  output logic                  load_start,
  output logic                  comp_start,
  output logic                  store_start,
  output logic                  busy,
`ifdef TILE_SEQ_PERF_EN
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_wait_cycles,
`endif
  output logic                  finish
);

  tile_seq_state_e       state;
  logic [CNT_WIDTH-1:0]  num_m_q;
  logic [CNT_WIDTH-1:0]  num_e_q;
  logic                  accept;
  logic                  e_more;
  logic                  m_more;
  logic                  step_e;
  logic                  step_m;

  // busy is still high during the finish cycle, so a start there is ignored too.
  assign accept = (state == ST_IDLE) && start && !busy;
  assign e_more = (tile_e_idx != (num_e_q - CNT_WIDTH'(1)));
  assign m_more = (tile_m_idx != (num_m_q - CNT_WIDTH'(1)));
  assign step_e = (state == ST_NEXT) && e_more;
  assign step_m = (state == ST_NEXT) && !e_more && m_more;

  tile_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk             (clk),
    .rst             (rst),
    .init            (accept),
    .step_e          (step_e),
    .step_m          (step_m),
    .ifmap_base      (dram_ifmap_base_addr),
    .filter_base     (dram_filter_base_addr),
    .bias_base       (dram_bias_base_addr),
    .opsum_base      (dram_opsum_base_addr),
    .ifmap_e_stride  (ifmap_e_stride),
    .filter_m_stride (filter_m_stride),
    .bias_m_stride   (bias_m_stride),
    .opsum_m_stride  (opsum_m_stride),
    .opsum_e_stride  (opsum_e_stride),
    .tile_ifmap_addr (tile_ifmap_addr),
    .tile_filter_addr(tile_filter_addr),
    .tile_bias_addr  (tile_bias_addr),
    .tile_opsum_addr (tile_opsum_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      num_m_q     <= '0;
      num_e_q     <= '0;
      tile_m_idx  <= '0;
      tile_e_idx  <= '0;
      load_start  <= 1'b0;
      comp_start  <= 1'b0;
      store_start <= 1'b0;
      busy        <= 1'b0;
      finish      <= 1'b0;
    end else begin
      load_start  <= 1'b0;
      comp_start  <= 1'b0;
      store_start <= 1'b0;
      finish      <= 1'b0;
      if (finish) busy <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            busy       <= 1'b1;
            num_m_q    <= num_m_tiles;
            num_e_q    <= num_e_tiles;
            tile_m_idx <= '0;
            tile_e_idx <= '0;
            if ((num_m_tiles == '0) || (num_e_tiles == '0)) begin
              state <= ST_DONE;
            end else begin
              state      <= ST_LOAD;
              load_start <= 1'b1;
            end
          end
        end
        ST_LOAD:      state <= ST_WAIT_LOAD;
        ST_WAIT_LOAD: begin
          if (load_done) begin
            state      <= ST_COMP;
            comp_start <= 1'b1;
          end
        end
        ST_COMP:      state <= ST_WAIT_COMP;
        ST_WAIT_COMP: begin
          if (comp_done) begin
            state       <= ST_STORE;
            store_start <= 1'b1;
          end
        end
        ST_STORE:      state <= ST_WAIT_STORE;
        ST_WAIT_STORE: if (store_done) state <= ST_NEXT;
        ST_NEXT: begin
          if (e_more) begin
            tile_e_idx <= tile_e_idx + CNT_WIDTH'(1);
            state      <= ST_LOAD;
            load_start <= 1'b1;
          end else if (m_more) begin
            tile_e_idx <= '0;
            tile_m_idx <= tile_m_idx + CNT_WIDTH'(1);
            state      <= ST_LOAD;
            load_start <= 1'b1;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          finish <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TILE_SEQ_PERF_EN
  logic in_wait;
  assign in_wait = (state == ST_WAIT_LOAD) || (state == ST_WAIT_COMP) ||
                   (state == ST_WAIT_STORE);

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      perf_busy_cycles <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (busy && !(&perf_busy_cycles)) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (in_wait && !(&perf_wait_cycles)) perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tile_sequencer.sv
`default_nettype none
// Scoreboard bench for tile_sequencer: each layer queues its expected tiles, a monitor pops on load_start.
module tb_tile_sequencer;

  typedef struct packed {
    logic [7:0]  m;
    logic [7:0]  e;
    logic [31:0] ifm;
    logic [31:0] fil;
    logic [31:0] bia;
    logic [31:0] ops;
  } tile_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_m_tiles = '0, num_e_tiles = '0;
  logic [31:0] ifmap_base = '0, filter_base = '0, bias_base = '0, opsum_base = '0;
  logic [31:0] ifmap_e_stride = '0, filter_m_stride = '0, bias_m_stride = '0;
  logic [31:0] opsum_m_stride = '0, opsum_e_stride = '0;
  logic        load_done = 1'b0, comp_done = 1'b0, store_done = 1'b0;
  logic [31:0] tile_ifmap_addr, tile_filter_addr, tile_bias_addr, tile_opsum_addr;
  logic [7:0]  tile_m_idx, tile_e_idx;
  logic        load_start, comp_start, store_start, busy, finish;
`ifdef TILE_SEQ_PERF_EN
  logic [31:0] perf_busy_cycles, perf_wait_cycles;
`endif

  tile_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .num_m_tiles(num_m_tiles), .num_e_tiles(num_e_tiles),
    .dram_ifmap_base_addr(ifmap_base), .dram_filter_base_addr(filter_base),
    .dram_bias_base_addr(bias_base), .dram_opsum_base_addr(opsum_base),
    .ifmap_e_stride(ifmap_e_stride), .filter_m_stride(filter_m_stride),
    .bias_m_stride(bias_m_stride), .opsum_m_stride(opsum_m_stride),
    .opsum_e_stride(opsum_e_stride),
    .load_done(load_done), .comp_done(comp_done), .store_done(store_done),
    .tile_ifmap_addr(tile_ifmap_addr), .tile_filter_addr(tile_filter_addr),
    .tile_bias_addr(tile_bias_addr), .tile_opsum_addr(tile_opsum_addr),
    .tile_m_idx(tile_m_idx), .tile_e_idx(tile_e_idx),
    .load_start(load_start), .comp_start(comp_start), .store_start(store_start),
    .busy(busy),
`ifdef TILE_SEQ_PERF_EN
    .perf_busy_cycles(perf_busy_cycles), .perf_wait_cycles(perf_wait_cycles),
`endif
    .finish(finish)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  tile_t exp_q[$];
  tile_t cur = '0;
  int load_cnt = 0, comp_cnt = 0, store_cnt = 0, finish_cnt = 0, busy_cnt = 0, tiles_seen = 0;
  int min_lat = 1, max_lat = 4;
  bit glitch_comp = 0, repulse = 0;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic tile_t dut_tile();
    tile_t t;
    t.m = tile_m_idx; t.e = tile_e_idx;
    t.ifm = tile_ifmap_addr; t.fil = tile_filter_addr;
    t.bia = tile_bias_addr; t.ops = tile_opsum_addr;
    return t;
  endfunction

  // Monitor: pops the reference tile on every load_start, checks stability on comp/store.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (load_start) begin
        load_cnt++;
        chk_int("load_start_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          tiles_seen++;
          chk("tile_at_load", dut_tile(), cur);
        end
      end
      if (comp_start) begin
        comp_cnt++;
        chk("tile_at_comp", dut_tile(), cur);
      end
      if (store_start) begin
        store_cnt++;
        chk("tile_at_store", dut_tile(), cur);
      end
      if (finish) begin
        finish_cnt++;
        chk_int("finish_tiles_left", exp_q.size(), 0);
      end
    end
  end

  // Sub-engine responders: done pulses a random number of cycles after each start.
  initial forever begin
    @(negedge clk);
    if (load_start && !rst) begin
      int lat = $urandom_range(max_lat, min_lat);
      bit g = glitch_comp;
      if (g) comp_done = 1'b1;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (i == 0 && g) comp_done = 1'b0;
      end
      load_done = 1'b1;
      @(negedge clk);
      load_done = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (comp_start && !rst) begin
      int lat = $urandom_range(max_lat, min_lat);
      bit r = repulse;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (r) start = (i == 0);
      end
      comp_done = 1'b1;
      @(negedge clk);
      comp_done = 1'b0;
      if (r) start = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (store_start && !rst) begin
      int lat = $urandom_range(max_lat, min_lat);
      for (int i = 0; i < lat; i++) @(negedge clk);
      store_done = 1'b1;
      @(negedge clk);
      store_done = 1'b0;
    end
  end

  task automatic launch(input int nm, input int ne, input logic [31:0] b [4], input logic [31:0] s [5]);
    for (int m = 0; m < nm; m++) begin
      for (int e = 0; e < ne; e++) begin
        tile_t t;
        t.m   = 8'(m);
        t.e   = 8'(e);
        t.ifm = b[0] + s[0] * 32'(e);
        t.fil = b[1] + s[1] * 32'(m);
        t.bia = b[2] + s[2] * 32'(m);
        t.ops = b[3] + s[3] * 32'(m) + s[4] * 32'(e);
        exp_q.push_back(t);
      end
    end
    load_cnt = 0; comp_cnt = 0; store_cnt = 0; busy_cnt = 0; tiles_seen = 0;
    @(negedge clk);
    num_m_tiles = 8'(nm); num_e_tiles = 8'(ne);
    ifmap_base = b[0]; filter_base = b[1]; bias_base = b[2]; opsum_base = b[3];
    ifmap_e_stride = s[0]; filter_m_stride = s[1]; bias_m_stride = s[2];
    opsum_m_stride = s[3]; opsum_e_stride = s[4];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_int("busy_after_start", int'(busy), 1);
    // Layer inputs are scrambled after acceptance; the DUT must not notice.
    num_m_tiles = 8'($urandom); num_e_tiles = 8'($urandom);
    ifmap_base = $urandom; filter_base = $urandom; bias_base = $urandom; opsum_base = $urandom;
    ifmap_e_stride = $urandom; filter_m_stride = $urandom; bias_m_stride = $urandom;
    opsum_m_stride = $urandom; opsum_e_stride = $urandom;
  endtask

  task automatic run_layer(input int nm, input int ne, input logic [31:0] b [4], input logic [31:0] s [5]);
    int f0 = finish_cnt;
    int tiles = nm * ne;
    launch(nm, ne, b, s);
    for (int i = 0; i < 5000 && finish_cnt == f0; i++) @(negedge clk);
    chk_int("finish_seen", finish_cnt - f0, 1);
    @(negedge clk);
    @(negedge clk);
    chk_int("busy_after_finish", int'(busy), 0);
    chk_int("load_pulses", load_cnt, tiles);
    chk_int("comp_pulses", comp_cnt, tiles);
    chk_int("store_pulses", store_cnt, tiles);
    chk_int("finish_pulses", finish_cnt - f0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] b [4];
    logic [31:0] s [5];
    tile_t zero_tile = '0;

    repeat (3) @(negedge clk);
    chk("reset_tile", dut_tile(), zero_tile);
    chk_int("reset_ctrl", int'({busy, finish, load_start, comp_start, store_start}), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1x1 layer, every done one cycle after its start
    b = '{32'd0, 32'd4096, 32'd8192, 32'd12288};
    s = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    min_lat = 1; max_lat = 1;
    run_layer(1, 1, b, s);

    // 2x3 layer with the reference strides
    s = '{32'h400, 32'h90, 32'h40, 32'h800, 32'h200};
    min_lat = 1; max_lat = 4;
    run_layer(2, 3, b, s);

    // zero-tile layer: no sub-engine activity, busy for exactly two cycles
    run_layer(3, 0, b, s);
    chk_int("zero_layer_busy_cycles", busy_cnt, 2);

    // start re-pulsed in WAIT_COMP and comp_done glitched during LOAD
    glitch_comp = 1; repulse = 1;
    run_layer(2, 2, b, s);
    glitch_comp = 0; repulse = 0;

    // reset in WAIT_COMP of the second tile, then a fresh run
    min_lat = 3; max_lat = 4;
    launch(2, 3, b, s);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (comp_start && tiles_seen == 2) break;
    end
    chk_int("reached_tile2_comp", tiles_seen, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tile", dut_tile(), zero_tile);
    chk_int("rst_mid_ctrl", int'({busy, finish, load_start, comp_start, store_start}), 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (10) @(negedge clk);
    min_lat = 1; max_lat = 4;
    run_layer(2, 2, b, s);

`ifdef TILE_SEQ_PERF_EN
    min_lat = 3; max_lat = 3;
    run_layer(1, 1, b, s);
    chk_int("perf_wait_cycles", int'(perf_wait_cycles), 9);
    chk_int("perf_busy_cycles", int'(perf_busy_cycles), 15);
    min_lat = 1; max_lat = 4;
`endif

    // random layers, including wrapping strides
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 4; j++) b[j] = $urandom;
      for (int j = 0; j < 5; j++) s[j] = (k % 2 == 0) ? 32'($urandom_range(4096, 1)) : $urandom;
      run_layer($urandom_range(3, 1), $urandom_range(4, 1), b, s);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tile_sequencer.md
# tile_sequencer

Tile-level controller that walks a convolution layer tile by tile and drives the three sub-engines in order: Tiling load (DRAM→GLB), PE-array compute, opsum store (GLB→DRAM). It sits between the host-visible layer registers and the Tiling/PE/store blocks. For each tile it generates the per-tile DRAM base addresses and start pulses, then raises `finish` once every tile has completed.

## Interface
- `ADDR_WIDTH`, 32, DRAM address width.
- `CNT_WIDTH`, 8, width of the tile counters and indices.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  layer start pulse; ignored unless `busy`=0.
- `num_m_tiles`, `num_e_tiles`  in  CNT_WIDTH  tile counts (output-channel tiles, output-row tiles); sampled on an accepted `start`.
- `dram_ifmap_base_addr`, `dram_filter_base_addr`, `dram_bias_base_addr`, `dram_opsum_base_addr`  in  ADDR_WIDTH  layer bases; sampled on an accepted `start`.
- `ifmap_e_stride`, `filter_m_stride`, `bias_m_stride`, `opsum_m_stride`, `opsum_e_stride`  in  ADDR_WIDTH  byte strides between tiles; sampled on an accepted `start`.
- `load_done`, `comp_done`, `store_done`  in  1  sub-engine completion (pulse or level).
- `tile_ifmap_addr`, `tile_filter_addr`, `tile_bias_addr`, `tile_opsum_addr`  out  ADDR_WIDTH  current-tile DRAM bases.
- `tile_m_idx`, `tile_e_idx`  out  CNT_WIDTH  current tile indices.
- `load_start`, `comp_start`, `store_start`  out  1  one-cycle start pulses.
- `busy`  out  1  high from the cycle after an accepted start through the cycle `finish` is high.
- `finish`  out  1  one-cycle layer-complete pulse.

## Operation
- Loop order: m outer, e inner (filter/bias fixed across the e loop).
- Addresses per tile:
  - `tile_ifmap_addr` = ifmap_base + e·ifmap_e_stride.
  - `tile_filter_addr` = filter_base + m·filter_m_stride.
  - `tile_bias_addr` = bias_base + m·bias_m_stride.
  - `tile_opsum_addr` = opsum_base + m·opsum_m_stride + e·opsum_e_stride.
  - Computed with running accumulators, no multipliers; modulo 2^ADDR_WIDTH, wrap is silent.
- FSM states: IDLE, LOAD, WAIT_LOAD, COMP, WAIT_COMP, STORE, WAIT_STORE, NEXT, DONE.
  - IDLE→LOAD on `start`. If either tile count is 0, IDLE→DONE instead and no sub-engine start is issued.
  - LOAD→WAIT_LOAD unconditionally. `load_start`=1 in LOAD only.
  - WAIT_LOAD→COMP on `load_done`.
  - COMP, WAIT_COMP, STORE, WAIT_STORE behave the same way with `comp_start`/`comp_done` and `store_start`/`store_done`.
  - WAIT_STORE→NEXT on `store_done`.
  - NEXT:
    - If e < num_e_tiles−1: e++, ifmap/opsum accumulators advance, go to LOAD.
    - Else if m < num_m_tiles−1: e=0, m++, accumulators reload/advance, go to LOAD.
    - Else go to DONE.
  - DONE: `finish`=1, then IDLE.
- Done inputs are sampled only in their own WAIT state. A done input seen in any other state, including the cycle of the matching start pulse, is ignored.
- `start` while busy is ignored. Layer parameter inputs may change after acceptance without effect.
- Reset outputs: all start pulses 0, `finish` 0, `busy` 0, indices 0, tile addresses 0, state IDLE.

## Timing
- `start` sampled high at edge N → state LOAD after N; `load_start` high for the cycle N..N+1.
- Tile addresses and indices are registered. They are valid from the first cycle of LOAD and stable through WAIT_STORE; they change only on leaving NEXT.
- Per-tile overhead is 4 cycles (LOAD, COMP, STORE, NEXT) plus the sub-engine latencies. Each done input costs at least 1 WAIT cycle.
- Last tile: NEXT→DONE; `finish` rises 2 cycles after `store_done` is sampled.
- Zero-count layer: `finish` is high in the cycle after the start edge.
- `rst` high at any edge, in any state, returns the block to its reset values on that edge. Start pulses already issued are not retracted.

## Configuration
- `TILE_SEQ_PERF_EN` defined: adds outputs `perf_busy_cycles` and `perf_wait_cycles`, both 32-bit.
  - `perf_busy_cycles` counts cycles with `busy`=1; `perf_wait_cycles` counts cycles spent in any WAIT_* state.
  - Both saturate at 2^32−1, clear on an accepted `start` and on `rst`, and hold their value after `finish`.
- Undefined: neither port nor counter exists.

## Structure
- Shared package `tile_seq_pkg`: state enum `tile_seq_state_e`, and `CNT_WIDTH`/`ADDR_WIDTH` defaults.
- One natural sub-module, `tile_addr_gen`: it holds the four address accumulators and takes the controls `init`, `step_e`, `step_m`. The FSM and the tile counters stay in `tile_sequencer`.

## Test plan
- 1×1 tiles, bases 0/4096/8192/12288, all done inputs 1 cycle after their start → exactly one pulse each of load/comp/store; `finish` pulses once; addresses equal the bases.
- m=2, e=3, ifmap_e_stride=0x400, filter_m_stride=0x90, opsum_m_stride=0x800, opsum_e_stride=0x200 → 6 tiles in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); the (1,2) tile has opsum 12288+0x800+0x400 and filter 4096+0x90.
- num_e_tiles=0 → `finish` in the cycle after start; `busy` high for 2 cycles; no start pulses.
- Re-pulse `start` during WAIT_COMP; hold `comp_done` high during LOAD → both ignored; tile order unchanged.
- Assert `rst` in WAIT_COMP of tile 2, then restart → all outputs 0 after the reset edge; the new run begins at tile (0,0).
- With `TILE_SEQ_PERF_EN`, 1×1 tile, each done 3 cycles after its start → `perf_wait_cycles`=9.
